// File: rtl/ee457_fetch_queue_if.sv
// Fetch-queue handshake bundle: ID-stage control, IMEM request/ack bus
// and the instruction presented to ID.
//   master : the fetch queue (drives IMEM_REQ/ADDR and ID_*)
//   slave  : the surrounding pipeline and instruction memory
interface ee457_fetch_queue_if #(
    parameter int AW = 6
);
    logic          STALL;
    logic          REDIRECT;
    logic [7:0]    REDIRECT_PC;
    logic          IMEM_REQ;
    logic [AW-1:0] IMEM_ADDR;
    logic          IMEM_ACK;
    logic [31:0]   IMEM_DATA;
    logic          ID_VALID;
    logic [31:0]   ID_INSTR;
    logic [7:0]    ID_PC;

    modport master (
        input  STALL,
        input  REDIRECT,
        input  REDIRECT_PC,
        input  IMEM_ACK,
        input  IMEM_DATA,
        output IMEM_REQ,
        output IMEM_ADDR,
        output ID_VALID,
        output ID_INSTR,
        output ID_PC
    );

    modport slave (
        output STALL,
        output REDIRECT,
        output REDIRECT_PC,
        output IMEM_ACK,
        output IMEM_DATA,
        input  IMEM_REQ,
        input  IMEM_ADDR,
        input  ID_VALID,
        input  ID_INSTR,
        input  ID_PC
    );
endinterface

// File: rtl/ee457_fetch_queue.sv
// Instruction-fetch front end: fetches words over a req/ack bus with
// wait states, buffers them in a DEPTH-entry prefetch queue, feeds ID.
// Ports:
//   CLK, RST : clock, async active-high reset
//   bus      : ee457_fetch_queue_if.master (STALL, REDIRECT,
//              REDIRECT_PC, IMEM_REQ/ADDR/ACK/DATA, ID_VALID/INSTR/PC)
module ee457_fetch_queue #(
    parameter int AW    = 6,
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    ee457_fetch_queue_if.master bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DISCARD
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
    } entry_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    fetch_pc_q;
    logic [AW-1:0] hold_addr_q;
    entry_t        queue_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          req;
    logic [AW-1:0] addr;
    logic          push;
    logic          pop;
    logic          full;
    logic          valid;
    logic          flush;
    logic          pending;
    entry_t        head;

    assign full    = (count_q == CW'(DEPTH));
    assign valid   = (count_q != '0);
    assign head    = queue_q[rd_ptr_q];
    assign flush   = bus.REDIRECT && (state_q != IDLE);
    // A request left open by a redirect must still be completed
    // on the bus, so its address is parked for DISCARD.
    assign pending = (state_q == RUN) && req && !bus.IMEM_ACK;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (bus.REDIRECT && pending) state_d = DISCARD;
            DISCARD: if (bus.IMEM_ACK) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req  = 1'b0;
        addr = '0;
        push = 1'b0;
        unique case (state_q)
            RUN: begin
                req  = !full;
                addr = fetch_pc_q[AW-1:0];
                push = req && bus.IMEM_ACK && !bus.REDIRECT;
            end
            DISCARD: begin
                req  = 1'b1;
                addr = hold_addr_q;
            end
            default: begin
                req  = 1'b0;
                addr = '0;
            end
        endcase
        pop = valid && !bus.STALL && !flush;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q  <= '0;
            hold_addr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else if (flush) begin
            fetch_pc_q <= bus.REDIRECT_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            if (pending) begin
                hold_addr_q <= fetch_pc_q[AW-1:0];
            end
        end else begin
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PW'(1);
                fetch_pc_q <= fetch_pc_q + 8'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case (1'b1)
                push && !pop: count_q <= count_q + CW'(1);
                pop && !push: count_q <= count_q - CW'(1);
                default:      count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count != 0.
    always_ff @(posedge CLK) begin
        if (push) begin
            queue_q[wr_ptr_q] <= '{instr: bus.IMEM_DATA, pc: fetch_pc_q};
        end
    end

    assign bus.IMEM_REQ  = req;
    assign bus.IMEM_ADDR = addr;
    assign bus.ID_VALID  = valid;
    assign bus.ID_INSTR  = valid ? head.instr : 32'h0;
    assign bus.ID_PC     = valid ? head.pc : 8'h0;

endmodule

// File: tb/tb_ee457_fetch_queue.sv
// Bench for ee457_fetch_queue: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ee457_fetch_queue;

    localparam int AW    = 6;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
    } ent_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    int   mem_wait = 0;
    int   wait_cnt = 0;
    logic spurious = 1'b0;

    ee457_fetch_queue_if #(.AW(AW)) bus ();

    ee457_fetch_queue #(.AW(AW), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    // Memory: ack after mem_wait cycles of REQ; data = 0x1000_0000+addr.
    assign bus.IMEM_ACK = spurious
        | (bus.IMEM_REQ && (wait_cnt >= mem_wait));
    assign bus.IMEM_DATA = 32'h1000_0000 + {26'b0, bus.IMEM_ADDR};

    always @(posedge CLK or posedge RST) begin
        if (RST) wait_cnt <= 0;
        else if (bus.IMEM_REQ && !bus.IMEM_ACK) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Reference model: 0 = idle, 1 = run, 2 = discard.
    ent_t       mq[$];
    logic [7:0] m_pc   = 8'h0;
    int         m_mode = 0;
    logic [5:0] m_daddr = 6'h0;
    bit         m_r;
    bit         m_a;

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            mq.delete();
            m_pc    = 8'h0;
            m_mode  = 0;
            m_daddr = 6'h0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: begin
                    m_r = (mq.size() < DEPTH);
                    m_a = m_r && bus.IMEM_ACK;
                    if (bus.REDIRECT) begin
                        mq.delete();
                        if (m_r && !m_a) begin
                            m_daddr = m_pc[AW-1:0];
                            m_mode  = 2;
                        end
                        m_pc = bus.REDIRECT_PC;
                    end else begin
                        if (mq.size() != 0 && !bus.STALL)
                            void'(mq.pop_front());
                        if (m_a) begin
                            mq.push_back('{bus.IMEM_DATA, m_pc});
                            m_pc = m_pc + 8'd1;
                        end
                    end
                end
                default: begin
                    if (bus.REDIRECT) m_pc = bus.REDIRECT_PC;
                    if (bus.IMEM_ACK) m_mode = 1;
                end
            endcase
        end
    end

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        logic        e_req;
        logic [5:0]  e_addr;
        logic        e_val;
        logic [31:0] e_ins;
        logic [7:0]  e_pc;
        @(negedge CLK);
        e_req  = (m_mode == 1) ? (mq.size() < DEPTH) : (m_mode == 2);
        e_addr = (m_mode == 2) ? m_daddr :
                 (m_mode == 1) ? m_pc[AW-1:0] : 6'h0;
        e_val  = (mq.size() != 0);
        e_ins  = e_val ? mq[0].instr : 32'h0;
        e_pc   = e_val ? mq[0].pc : 8'h0;
        check("model_req",   {31'b0, bus.IMEM_REQ}, {31'b0, e_req});
        check("model_addr",  {26'b0, bus.IMEM_ADDR}, {26'b0, e_addr});
        check("model_valid", {31'b0, bus.ID_VALID}, {31'b0, e_val});
        check("model_instr", bus.ID_INSTR, e_ins);
        check("model_pc",    {24'b0, bus.ID_PC}, {24'b0, e_pc});
    end

    task automatic step(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_id(string name, logic v, logic [7:0] pc,
                          logic [31:0] ins);
        check({name, "_valid"}, {31'b0, bus.ID_VALID}, {31'b0, v});
        check({name, "_pc"}, {24'b0, bus.ID_PC}, {24'b0, pc});
        check({name, "_instr"}, bus.ID_INSTR, ins);
    endtask

    task automatic chk_req(string name, logic r, logic [5:0] a);
        check({name, "_req"}, {31'b0, bus.IMEM_REQ}, {31'b0, r});
        check({name, "_addr"}, {26'b0, bus.IMEM_ADDR}, {26'b0, a});
    endtask

    initial begin
        bus.STALL       = 1'b0;
        bus.REDIRECT    = 1'b0;
        bus.REDIRECT_PC = 8'h0;

        // Zero-wait start-up
        step(2);
        chk_req("rst", 1'b0, 6'h0);
        chk_id("rst", 1'b0, 8'h0, 32'h0);
        RST = 1'b0;
        step(1);
        chk_req("start", 1'b1, 6'h0);
        check("start_novalid", {31'b0, bus.ID_VALID}, 32'h0);
        step(1);
        chk_id("first", 1'b1, 8'h0, 32'h1000_0000);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk_id("stream", 1'b1, 8'(k), 32'h1000_0000 + k);
        end

        // Stall 8 cycles; spurious acks while full must be ignored
        bus.STALL = 1'b1;
        spurious  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk_id("stall_hold", 1'b1, 8'h5, 32'h1000_0005);
            if (k >= 3)
                check("stall_full_req", {31'b0, bus.IMEM_REQ}, 32'h0);
        end
        bus.STALL = 1'b0;
        spurious  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk_id("unstall", 1'b1, 8'(5 + k), 32'h1000_0005 + k);
        end

        // Async reset pulse mid-stream
        RST = 1'b1;
        #1;
        chk_req("async_rst", 1'b0, 6'h0);
        chk_id("async_rst", 1'b0, 8'h0, 32'h0);
        step(2);
        RST = 1'b0;
        step(1);
        chk_req("restart", 1'b1, 6'h0);
        step(1);
        chk_id("restart", 1'b1, 8'h0, 32'h1000_0000);
        step(1);
        chk_id("restart2", 1'b1, 8'h1, 32'h1000_0001);

        // Two wait states
        RST = 1'b1;
        mem_wait = 2;
        step(2);
        RST = 1'b0;
        step(1);
        chk_req("ws_e1", 1'b1, 6'h0);
        step(1);
        chk_req("ws_e2", 1'b1, 6'h0);
        step(1);
        chk_req("ws_e3", 1'b1, 6'h0);
        check("ws_e3_novalid", {31'b0, bus.ID_VALID}, 32'h0);
        step(1);
        chk_id("ws_e4", 1'b1, 8'h0, 32'h1000_0000);
        chk_req("ws_e4", 1'b1, 6'h1);
        step(1);
        chk_id("ws_e5", 1'b0, 8'h0, 32'h0);
        step(2);
        chk_id("ws_e7", 1'b1, 8'h1, 32'h1000_0001);
        step(3);
        chk_id("ws_e10", 1'b1, 8'h2, 32'h1000_0002);

        // Redirect while request for address 5 is pending
        step(7);
        chk_req("pend5", 1'b1, 6'h5);
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 8'h08;
        step(1);
        chk_req("disc", 1'b1, 6'h5);
        check("disc_novalid", {31'b0, bus.ID_VALID}, 32'h0);
        bus.REDIRECT_PC = 8'h10;
        step(1);
        bus.REDIRECT = 1'b0;
        chk_req("post_disc", 1'b1, 6'h10);
        check("post_disc_nov", {31'b0, bus.ID_VALID}, 32'h0);
        step(3);
        chk_id("redir10", 1'b1, 8'h10, 32'h1000_0010);

        // Redirect coincident with ack, pop and count=3
        RST = 1'b1;
        mem_wait  = 0;
        bus.STALL = 1'b1;
        step(2);
        RST = 1'b0;
        step(4);
        chk_id("fill3", 1'b1, 8'h0, 32'h1000_0000);
        chk_req("fill3", 1'b1, 6'h3);
        bus.STALL       = 1'b0;
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 8'h30;
        step(1);
        bus.REDIRECT = 1'b0;
        chk_id("flush", 1'b0, 8'h0, 32'h0);
        chk_req("flush", 1'b1, 6'h30);
        step(1);
        chk_id("redir30", 1'b1, 8'h30, 32'h1000_0030);
        step(1);
        chk_id("redir31", 1'b1, 8'h31, 32'h1000_0031);

        // Fetch PC wrap-around
        bus.REDIRECT    = 1'b1;
        bus.REDIRECT_PC = 8'hFE;
        step(1);
        bus.REDIRECT = 1'b0;
        chk_req("wrap_req", 1'b1, 6'h3E);
        check("wrap_nov", {31'b0, bus.ID_VALID}, 32'h0);
        step(1);
        chk_id("wrapFE", 1'b1, 8'hFE, 32'h1000_003E);
        step(1);
        chk_id("wrapFF", 1'b1, 8'hFF, 32'h1000_003F);
        step(1);
        chk_id("wrap00", 1'b1, 8'h00, 32'h1000_0000);
        step(1);
        chk_id("wrap01", 1'b1, 8'h01, 32'h1000_0001);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
